// File: rtl/muxnway_rr_if.sv
// Handshake bundle between N word producers, the channel mux and its single consumer.
interface muxnway_rr_if #(
    parameter int N  = 4,
    parameter int W  = 16,
    parameter int SW = $clog2(N)
);
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [SW-1:0]  sel;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [SW-1:0]  out_chan;

    // Environment side: producers plus consumer.
    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_valid, out_chan
    );

    // Mux side.
    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_valid, out_chan
    );
endinterface

// File: rtl/muxnway_rr.sv
// N-way word mux with a registered valid/ready output stage.
// MODE=0 takes the channel from sel; MODE=1 arbitrates round-robin starting at ptr.
module muxnway_rr #(
    parameter int N    = 4,
    parameter int W    = 16,
    parameter int MODE = 0,
    parameter int SW   = $clog2(N)
) (
    input  logic        clk,
    input  logic        reset,
    muxnway_rr_if.slave bus
);
    logic [SW-1:0] ptr;
    logic [SW-1:0] grant_idx;
    logic          grant_vld;
    logic [W-1:0]  grant_word;
    logic [N-1:0]  ready;
    logic          load;
    logic          xfer;
    logic [W-1:0]  data_q;
    logic [SW-1:0] chan_q;
    logic          valid_q;

    // The output register can accept a word when empty or being drained this cycle.
    assign load = !valid_q || bus.out_ready;
    assign xfer = !reset && load && grant_vld;

    assign bus.in_ready  = ready;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_chan  = chan_q;

    // Pick the granted channel: explicit select, or first requester at or after ptr with wrap.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (MODE == 0) begin
            // An out-of-range sel matches no channel, so it never grants.
            for (int i = 0; i < N; i++) begin
                if (int'(bus.sel) == i && bus.in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = SW'(i);
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!grant_vld && bus.in_valid[i] && i >= int'(ptr)) begin
                    grant_vld = 1'b1;
                    grant_idx = SW'(i);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!grant_vld && bus.in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = SW'(i);
                end
            end
        end
    end

    // Route the granted channel's word and raise its ready; ready is held low during reset.
    always_comb begin
        grant_word = '0;
        ready      = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == SW'(i)) begin
                grant_word = bus.in_data[i*W +: W];
            end
            if (xfer && grant_idx == SW'(i)) begin
                ready[i] = 1'b1;
            end
        end
    end

    // Output register and round-robin pointer; a push may replace a word popped on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            ptr     <= '0;
        end else if (xfer) begin
            data_q  <= grant_word;
            chan_q  <= grant_idx;
            valid_q <= 1'b1;
            if (MODE == 1) begin
                ptr <= (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);
            end
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end
endmodule

// File: doc/muxnway_rr.md
# muxnway_rr

Parametrised successor to the combinational `mux4way16`. It selects among N input channels of W bits each and delivers one word per cycle through a registered valid/ready output stage. Channel selection is either explicit through `sel`, as in the plain mux, or by fair round-robin arbitration. It sits between multiple word producers (ALU result, memory read, I/O) and a single consumer such as the register-write or bus path.

## Interface
Parameters:
- `N`, default 4: number of input channels, at least 2.
- `W`, default 16: data width in bits.
- `MODE`, default 0: 0 = explicit select via `sel`; 1 = round-robin arbitration, `sel` ignored.
- `SW`, default `$clog2(N)`: width of `sel` and `out_chan`. Never overridden.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `in_data`, input, N*W: packed channel data; channel i is `in_data[i*W +: W]`.
- `in_valid`, input, N: per-channel valid.
- `in_ready`, output, N: per-channel ready; at most one bit set.
- `sel`, input, SW: requested channel; used only when MODE=0.
- `out_data`, output, W: registered output word.
- `out_valid`, output, 1: `out_data` holds an undelivered word.
- `out_ready`, input, 1: consumer accepts the word this cycle.
- `out_chan`, output, SW: index of the channel that supplied `out_data`.

## Operation
- `load = !out_valid || out_ready`. The output register may take a new word only when `load` is 1.
- Grant, combinational:
  - MODE=0: grant `sel` if `sel < N` and `in_valid[sel]`; otherwise no grant.
  - MODE=1: search the channels `ptr, ptr+1, …, N-1, 0, …, ptr-1`; the first channel with `in_valid` set wins. No grant if `in_valid` is 0.
- `in_ready[g] = load && grant == g`. All other `in_ready` bits are 0. A transfer on channel g occurs when `in_valid[g] && in_ready[g]`.
- On a transfer:
  - `out_data <= in_data[g]`, `out_chan <= g`, `out_valid <= 1`.
  - MODE=1 only: `ptr <= (g == N-1) ? 0 : g+1`.
- When `out_valid && out_ready` and there is no transfer, `out_valid <= 0`. `out_data` and `out_chan` keep their last values.
- `ptr` is an internal register of SW bits, reset to 0. It changes only on a transfer. It is unused in MODE=0.
- An unselected channel is never dropped: its data simply waits, with `in_ready` low.
- Reset values: `out_valid = 0`, `out_data = 0`, `out_chan = 0`, `ptr = 0`. `in_ready` is 0 while `reset` is high, regardless of the other inputs.
- Reset mid-operation discards any held word. No partial state survives.

## Timing
- Latency is 1 cycle: a word transferred at edge k appears on `out_data` with `out_valid = 1` after edge k.
- Throughput is 1 word per cycle when `out_ready` is held high.
- Backpressure: while `out_valid && !out_ready`, the output register and `ptr` are frozen and all `in_ready` bits are 0.
- Simultaneous pop and push, when `out_valid`, `out_ready` and a grant coincide: the new word replaces the old one in the same edge. There is no bubble cycle.
- `in_ready` depends combinationally on `in_valid`, `sel` and `out_ready`. It never depends on `in_data`. Producers must not make `in_valid` depend on `in_ready`.
- Sources hold `in_data` and `in_valid` stable until their transfer occurs.

## Test plan
Default instance is N=4, W=16, with `in_data` channel i = 0x1111*(i+1).

1. Reset: hold `reset=1` for 2 cycles with `in_valid=4'b1111` and `out_ready=1`. Require `in_ready=0000`, `out_valid=0`, `out_data=0x0000`, `out_chan=0`. After release in MODE=1, the first `out_chan` is 0.
2. MODE=0 select: `sel=2`, `in_valid=1111`, `out_ready=1`. Require `in_ready=0100`; next cycle `out_data=0x3333`, `out_chan=2`. Then drive `sel=3` with `in_valid=0111`: require `in_ready=0000` and `out_valid` falling to 0.
3. MODE=1 fairness: `in_valid=1111` and `out_ready=1` for 5 cycles. Require `out_chan` to run 0,1,2,3,0 and `out_data` to run 0x1111, 0x2222, 0x3333, 0x4444, 0x1111, with `out_valid` continuously 1.
4. Backpressure: after the first word, set `out_ready=0` for 3 cycles. Require `out_data` to hold 0x1111, `in_ready=0000`, and `ptr` not to advance. On releasing `out_ready=1`, the next word is 0x2222.
5. Sparse requests, MODE=1: `in_valid=1010` with `out_ready=1`. Require `out_chan` to run 1,3,1,3. Then, at the cycle `out_chan` shows 3, drop the requests so `in_valid=0000`. Require `out_valid=0` on the following cycle.
6. Reset mid-stream plus odd N: on an N=3 instance in MODE=0, drive `sel=3` (out of range) and require no grant, ever. On the MODE=1 default instance, assert `reset` while `out_valid=1` and `out_ready=0`. Require `out_valid=0`, `out_data=0`, and the first post-reset grant to go to channel 0.
